mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline: consumes the EX/MEM register outputs and performs the data-memory access.
//  - Owns a little-endian, byte-enabled data RAM.
//  - Executes SB/SH/SW stores and LB/LBU/LH/LHU/LW loads with sign/zero extension.
//  - Registers results into the MEM/WB pipeline register feeding WB and the forwarding unit.
//  - Exposes a word-wide debug read port used while the pipeline is halted.
// PARAMETERS
//  NB_DATA   32  datapath width
//  NB_ADDR   8   word-address bits; RAM depth = 2**NB_ADDR words
// PORTS
//  clk             in   1        clock, rising edge
//  i_reset         in   1        asynchronous, active-low reset (0 = reset)
//  i_halt          in   1        freeze: no RAM write, MEM/WB register holds
//  i_mem2reg       in   1        EX/MEM: WB selects load data
//  i_memWrite      in   1        EX/MEM: store enable
//  i_regWrite      in   1        EX/MEM: register-file write enable
//  i_width         in   2        00 byte, 01 half, 10/11 word
//  i_sign_flag     in   1        1 sign-extend loads, 0 zero-extend
//  i_write_reg     in   5        destination register
//  i_result        in   NB_DATA  ALU result = byte address for ld/st
//  i_data4Mem      in   NB_DATA  store data (forwarded rt)
//  i_dbg_addr      in   NB_ADDR  debug word address
//  o_dbg_data      out  NB_DATA  RAM[i_dbg_addr], combinational
//  o_mem2reg       out  1        MEM/WB copy
//  o_regWrite      out  1        MEM/WB copy; forced 0 on misaligned load
//  o_write_reg     out  5        MEM/WB copy
//  o_read_data     out  NB_DATA  extended load data
//  o_alu_result    out  NB_DATA  MEM/WB copy of i_result
//  o_misaligned    out  1        registered alignment fault of the access
// BEHAVIOUR
//  - Reset (async, i_reset=0): all MEM/WB outputs 0. RAM contents are not reset.
//  - Addressing: word index = i_result[NB_ADDR+1:2]; lane = i_result[1:0]. Upper bits are ignored (wrap-around).
//  - Alignment: half needs lane[0]=0; word needs lane=00.
//    - A violation on a store or load sets misalign.
//    - A misaligned store writes nothing.
//    - A misaligned load is registered with o_regWrite=0.
//  - Store, rising edge, when i_memWrite & ~i_halt & ~misalign:
//    - byte: byte enable 1<<lane, data i_data4Mem[7:0] on that lane.
//    - half: enables 0011 or 1100, data i_data4Mem[15:0].
//    - word: enables 1111, full word.
//  - Load: combinational read of the addressed word, select lane, extend per i_sign_flag. Word loads ignore the sign flag.
//  - Latency: 1 cycle. Inputs at edge N appear on the MEM/WB outputs after edge N.
//  - RAW on RAM: a store at edge N followed by a load of the same address in the next cycle returns the new data. No bypass is needed.
//  - o_read_data is updated for every instruction. It is meaningful only when o_mem2reg=1.
//  - i_halt=1: the MEM/WB register holds all values and RAM writes are blocked.
//    - The debug port stays live.
//    - On deassertion, the held instruction resumes normally with no replay.
//  - Reset mid-store: the write is dropped if i_reset=0 at the edge. Outputs clear immediately.
//  - Debug port: a pure read. It never affects pipeline state and may be read at any time.
// STRUCTURE
//  - Shared package (cpu_pkg): WIDTH_BYTE/HALF/WORD encodings, NB_DATA, NB_REG=5.
//  - Sub-module data_ram: byte-enabled word RAM.
//    - Ports: clk, i_we[3:0], i_waddr, i_wdata, i_raddr, o_rdata, i_dbg_addr, o_dbg_data.
//    - No reset.
//  - MEM/WB register inline in mem_stage: one always block with async active-low reset.
// TESTING
//  1. Reset: i_reset=0 mid-run -> all outputs 0 immediately. Release, then SW 0xDEADBEEF @0x10 -> dbg_addr=4 reads 0xDEADBEEF.
//  2. Byte stores: SB 0x11/0x22/0x33/0x44 @0x20..0x23 -> word 8 = 0x44332211.
//     - LB @0x23 sign=1 -> 0x00000044.
//     - Store 0xF0 @0x23, then LB @0x23 -> 0xFFFFFFF0; LBU -> 0x000000F0.
//  3. Half: SH 0x8001 @0x32 over word 0 -> word 12 = 0x80010000.
//     - LH @0x32 -> 0xFFFF8001; LHU -> 0x00008001.
//  4. Misaligned: SW @0x41 -> RAM unchanged, o_misaligned=1.
//     - LH @0x43 -> o_misaligned=1, o_regWrite=0.
//  5. Halt: i_halt=1 with SW pending -> no write, outputs frozen for 5 cycles.
//     - Release -> write lands, outputs advance 1 cycle later.
//  6. Back-to-back: SW 0x12345678 @0x50 then LW @0x50 next cycle -> o_read_data=0x12345678.
//     - Latency is exactly 1 edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and
// load/store access-width encodings.
package cpu_pkg;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_BE   = NB_DATA / 8;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  // Alignment fault for an access of the given width.
  function automatic logic misalign_f(
    input logic [1:0] width,
    input logic [1:0] lane
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (width == WIDTH_BYTE): bad = 1'b0;
      (width == WIDTH_HALF): bad = lane[0];
      default:               bad = |lane;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Byte-enabled little-endian word RAM with a
// combinational access read and a debug read port.
import cpu_pkg::*;

module data_ram #(
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic [NB_BE-1:0]   i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data
);

  logic [NB_DATA-1:0] r_mem [2**NB_ADDR];

  // Write each enabled byte lane of the addressed word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB_BE; b++) begin
      if (i_we[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata    = r_mem[i_raddr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access, load
// extension and the MEM/WB pipeline register.
import cpu_pkg::*;

module mem_stage #(
  parameter int NB_DATA = cpu_pkg::NB_DATA,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_mem2reg,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic               o_misaligned
);

  logic [NB_ADDR-1:0] w_widx;
  logic [1:0]         w_lane;
  logic               w_misalign;
  logic               w_fault;
  logic [3:0]         w_be;
  logic [3:0]         w_we;
  logic [NB_DATA-1:0] w_wdata;
  logic [NB_DATA-1:0] w_rdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [NB_DATA-1:0] w_load;

  logic               r_mem2reg;
  logic               r_regWrite;
  logic [4:0]         r_write_reg;
  logic [NB_DATA-1:0] r_read_data;
  logic [NB_DATA-1:0] r_alu_result;
  logic               r_misaligned;

  assign w_widx     = i_result[NB_ADDR+1:2];
  assign w_lane     = i_result[1:0];
  assign w_misalign = misalign_f(i_width, w_lane);
  assign w_fault    = w_misalign & (i_memWrite | i_mem2reg);

  // Store lane enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_data4Mem;
    unique case (1'b1)
      (i_width == WIDTH_BYTE): begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_data4Mem[7:0]}};
      end
      (i_width == WIDTH_HALF): begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_data4Mem[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_data4Mem;
      end
    endcase
  end

  // Writes are dropped under halt, fault or reset.
  assign w_we = (i_memWrite & ~i_halt & ~w_misalign & i_reset)
              ? w_be : 4'b0000;

  data_ram #(
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clk        (clk),
    .i_we       (w_we),
    .i_waddr    (w_widx),
    .i_wdata    (w_wdata),
    .i_raddr    (w_widx),
    .o_rdata    (w_rdata),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    w_byte = w_rdata[7:0];
    unique case (w_lane)
      2'd0:    w_byte = w_rdata[7:0];
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      default: w_byte = w_rdata[31:24];
    endcase
    w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_load = w_rdata;
    unique case (1'b1)
      (i_width == WIDTH_BYTE):
        w_load = {{(NB_DATA-8){i_sign_flag & w_byte[7]}}, w_byte};
      (i_width == WIDTH_HALF):
        w_load = {{(NB_DATA-16){i_sign_flag & w_half[15]}}, w_half};
      default:
        w_load = w_rdata;
    endcase
  end

  // MEM/WB register; holds while halted.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_mem2reg    <= 1'b0;
      r_regWrite   <= 1'b0;
      r_write_reg  <= '0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_misaligned <= 1'b0;
    end else if (!i_halt) begin
      r_mem2reg    <= i_mem2reg;
      r_regWrite   <= i_regWrite & ~(w_misalign & i_mem2reg);
      r_write_reg  <= i_write_reg;
      r_read_data  <= w_load;
      r_alu_result <= i_result;
      r_misaligned <= w_fault;
    end
  end

  assign o_mem2reg    = r_mem2reg;
  assign o_regWrite   = r_regWrite;
  assign o_write_reg  = r_write_reg;
  assign o_read_data  = r_read_data;
  assign o_alu_result = r_alu_result;
  assign o_misaligned = r_misaligned;

endmodule
